// File: rtl/axi_wr_chan_pkg.sv
// rtl/axi_wr_chan_pkg.sv - shared types and constants for the AXI write-channel demux
package axi_wr_chan_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } wr_state_e;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  localparam int CH_HI    = 7;
  localparam int CH_LO    = 4;
  localparam int LAST_BIT = 0;

endpackage

// File: rtl/axi_beat_counter.sv
// rtl/axi_beat_counter.sv - burst beat counter: loads awlen, counts down per W handshake
module axi_beat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] len,
  input  logic       dec,
  output logic       is_last
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= len;
    end else if (dec && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
    end
  end

  // The beat accepted while the count sits at zero closes the burst.
  assign is_last = (cnt == 8'd0);

endmodule

// File: rtl/axi_wr_chan_demux.sv
// rtl/axi_wr_chan_demux.sv - AXI4 write slave steering each beat into one of NUM_CH FIFOs
// Optional: AXI_WLAST_CHECK_EN turns an s_wlast / beat-count disagreement into SLVERR.
module axi_wr_chan_demux
  import axi_wr_chan_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [31:0]         s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [NUM_CH-1:0]   ch_full,
  output logic [NUM_CH-1:0]   ch_clr,
  output logic [NUM_CH-1:0]   ch_push,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [IDX_W-1:0]    index
);

  wr_state_e         state, next_state;
  logic [3:0]        cur_ch;
  logic              last_flag;
  logic              err_flag;
  logic              inc_pending;
  logic              is_last;
  logic              aw_hs;
  logic              w_hs;
  logic              wlast_bad;
  logic              beat_err;
  logic [15:0]       ch_full_ext;
  logic [NUM_CH-1:0] push_sel;
  logic              unused_addr;

  // Widened so an unmapped channel number indexes a zero instead of running off the vector.
  assign ch_full_ext = 16'(ch_full);
  assign s_wready    = (state == ST_DATA) && (err_flag || !ch_full_ext[cur_ch]);
  assign aw_hs       = s_awready && s_awvalid;
  assign w_hs        = s_wvalid && s_wready;
  assign unused_addr = ^{s_awaddr[31:CH_HI+1], s_awaddr[CH_LO-1:LAST_BIT+1]};

`ifdef AXI_WLAST_CHECK_EN
  assign wlast_bad = (s_wlast != is_last);
`else
  logic unused_wlast;
  assign unused_wlast = s_wlast;
  assign wlast_bad    = 1'b0;
`endif

  assign beat_err = err_flag || wlast_bad;

  axi_beat_counter u_beat_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (aw_hs),
    .len     (s_awlen),
    .dec     (w_hs),
    .is_last (is_last)
  );

  always_comb begin
    push_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      push_sel[i] = (cur_ch == 4'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    s_awready  = 1'b0;
    s_bvalid   = 1'b0;
    ch_clr     = '0;
    case (state)
      ST_INIT: begin
        // Clear pulse is held off while reset is still asserted.
        ch_clr     = reset ? '0 : '1;
        next_state = ST_ADDR;
      end
      ST_ADDR: begin
        s_awready = 1'b1;
        if (s_awvalid) next_state = ST_DATA;
      end
      ST_DATA: begin
        if (w_hs && is_last) next_state = ST_RESP;
      end
      ST_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) next_state = ST_ADDR;
      end
      default: next_state = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_ch      <= 4'd0;
      last_flag   <= 1'b0;
      err_flag    <= 1'b0;
      inc_pending <= 1'b0;
      s_bid       <= '0;
      s_bresp     <= BRESP_OKAY;
      ch_push     <= '0;
      wdata       <= '0;
      wstrb       <= '0;
      index       <= '0;
    end else begin
      ch_push     <= '0;
      inc_pending <= 1'b0;
      if (state == ST_INIT) index <= '0;
      // Record index advances the cycle after the closing push of a last-flagged record.
      if (inc_pending) index <= index + 1'b1;
      if (aw_hs) begin
        s_bid     <= s_awid;
        cur_ch    <= s_awaddr[CH_HI:CH_LO];
        last_flag <= s_awaddr[LAST_BIT];
        err_flag  <= (int'(s_awaddr[CH_HI:CH_LO]) >= NUM_CH);
      end
      if (w_hs) begin
        err_flag <= beat_err;
        if (!beat_err) begin
          ch_push <= push_sel;
          wdata   <= s_wdata;
          wstrb   <= s_wstrb;
        end
        if (is_last) begin
          s_bresp     <= beat_err ? BRESP_SLVERR : BRESP_OKAY;
          inc_pending <= last_flag && !beat_err;
        end
      end
    end
  end

endmodule
